// File: rtl/cla_pkg.sv
// Shared definitions for the serial CLA adder/subtractor: slice width,
// FSM state encoding and the signed saturation helper.
package cla_pkg;

  localparam int SLICE_W   = 4;
  // Widest result the saturation helper can build; callers cast down to WIDTH.
  localparam int SAT_MAX_W = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Signed saturation value for a width-bit result:
  // msb=0 -> 0x7F..F (positive limit), msb=1 -> 0x80..0 (negative limit).
  function automatic logic [SAT_MAX_W-1:0] sat_value(input logic msb, input int width);
    logic [SAT_MAX_W-1:0] one;
    logic [SAT_MAX_W-1:0] lim;
    one = SAT_MAX_W'(1);
    lim = one << (width - 1);
    if (!msb) lim = lim - one;
    return lim;
  endfunction

endpackage

// File: rtl/cla_nibble_slice.sv
// Combinational 4-bit carry-lookahead slice. Also exposes the carry into
// bit 3 so the caller can form signed overflow on the top slice.
module cla_nibble_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       c3
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;

  assign g = x & y;
  assign p = x ^ y;

  // Lookahead carries, each computed directly from generate/propagate terms.
  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/cla_serial_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor: one 4-bit CLA slice per clock,
// LSB slice first, with a registered carry between slices.
// Optional feature macro: ADDSUB_SAT_EN -- when defined, an overflowing
// result is replaced by the signed saturation value (latency unchanged).
module cla_serial_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;      // already inverted in subtract mode
  logic             carry_q;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] sum_upd;

  logic [3:0] x;
  logic [3:0] y;
  logic [3:0] s;
  logic       co;
  logic       c3;
  logic       accept;
  logic       consume;
  logic       last;

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;
  assign last    = (k == K_LAST);

  // The single shared slice works on nibble k of the registered operands.
  assign x = a_q[int'(k)*SLICE_W +: SLICE_W];
  assign y = b_q[int'(k)*SLICE_W +: SLICE_W];

  cla_nibble_slice u_slice (
    .x  (x),
    .y  (y),
    .ci (carry_q),
    .s  (s),
    .co (co),
    .c3 (c3)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (accept) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (last) state_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Result with the current slice merged in; saturates on the final slice when enabled.
  always_comb begin
    sum_upd = sum;
    sum_upd[int'(k)*SLICE_W +: SLICE_W] = s;
`ifdef ADDSUB_SAT_EN
    if (last && (co ^ c3)) sum_upd = WIDTH'(sat_value(a_q[WIDTH-1], WIDTH));
`endif
  end

  // Operand capture on accept, then one slice per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      k       <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub ? 1'b1 : cin;
      k       <= '0;
    end else if (state == ST_RUN) begin
      sum     <= sum_upd;
      carry_q <= co;
      if (last) begin
        k    <= '0;
        cout <= co;
        ovf  <= co ^ c3;
      end else begin
        k <= k + KW'(1);
      end
    end
  end

endmodule

// File: tb/tb_cla_serial_addsub.sv
// Directed self-checking bench for cla_serial_addsub (WIDTH=16).
module tb_cla_serial_addsub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  cla_serial_addsub #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Issue one operation, check latency and result, optionally stall the
  // consumer for 'hold' clocks (with an ignored in_valid pulse), then consume.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic ts, input logic tc, input logic [15:0] esum,
                        input logic ecout, input logic eovf, input int hold);
    int cycles;
    @(negedge clk);
    a = ta; b = tb_v; sub = ts; cin = tc; in_valid = 1'b1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~ta; b = ~tb_v; sub = ~ts; cin = ~tc;   // later changes must not matter
    cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (out_valid) break;
    end
    check({tag, "_latency"}, 32'(cycles), 32'd4);
    check({tag, "_sum"}, 32'(sum), 32'(esum));
    check({tag, "_cout_ovf"}, 32'({cout, ovf}), 32'({ecout, eovf}));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (i == 1) begin
        a = 16'h0101; b = 16'h0202; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      check({tag, "_hold_stable"}, {out_valid, in_ready, cout, ovf, 12'd0, sum},
            {1'b1, 1'b0, ecout, eovf, 12'd0, esum});
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_consumed"}, 32'({out_valid, in_ready}), 32'b01);
  endtask

  logic [15:0] sat_pos;
  logic [15:0] sat_neg;

  initial begin
`ifdef ADDSUB_SAT_EN
    sat_pos = 16'h7FFF;
    sat_neg = 16'h8000;
`else
    sat_pos = 16'h8000;
    sat_neg = 16'h7FFF;
`endif
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    #12;
    check("reset_hs", 32'({in_ready, out_valid}), 32'b10);
    check("reset_res", 32'({cout, ovf, sum}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain add, latency, and carry ripple through every slice.
    run_op("t1", 16'h000F, 16'h0000, 1'b0, 1'b0, 16'h000F, 1'b0, 1'b0, 0);
    run_op("t2", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    run_op("cin", 16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 0);
    // Signed overflow in both directions.
    run_op("t3_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, sat_pos, 1'b0, 1'b1, 0);
    run_op("t3_sub", 16'h8000, 16'h0001, 1'b1, 1'b0, sat_neg, 1'b1, 1'b1, 0);
    // Subtract with borrow, and cin ignored in subtract mode.
    run_op("t4_borrow", 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 0);
    run_op("t4_cin", 16'h0008, 16'h0007, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 0);
    // Back-pressure: five stalled clocks in DONE with an ignored request.
    run_op("t5", 16'h1000, 16'h2222, 1'b0, 1'b0, 16'h3222, 1'b0, 1'b0, 5);
    repeat (2) @(posedge clk);
    #1;
    check("t5_nothing_queued", 32'({out_valid, in_ready}), 32'b01);

    // Reset during the 2nd RUN cycle aborts the operation.
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_abort_hs", 32'({in_ready, out_valid}), 32'b10);
    check("t6_abort_res", 32'({cout, ovf, sum}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("t6_after", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
